board_row_fetcher: RTL and testbench
====================================

BOARD_ROW_FETCHER -- requirements
Module: board_row_fetcher

Interface
REQ-001 SHALL have parameter BOARD_W, default 10, cells per board row.
REQ-002 SHALL have parameter BOARD_H, default 20, rows per board.
REQ-003 SHALL have parameter CELL_W, default 16, bits per cell colour word ([11:8] R, [7:4] G, [3:0] B).
REQ-004 SHALL have port Clk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port LD_Row  input  1  row-load request from color_mapper; level, may stay high many cycles.
REQ-007 SHALL have port rowNum  input  8  board row index requested, sampled with LD_Row.
REQ-008 SHALL have port mem_rd  output  1  board RAM read strobe.
REQ-009 SHALL have port mem_addr  output  8  board RAM cell address, row*BOARD_W+col.
REQ-010 SHALL have port mem_rdata  input  CELL_W  board RAM data, valid exactly 1 cycle after mem_rd.
REQ-011 SHALL have port Row  output  BOARD_W x CELL_W  committed row image, Row[col].
REQ-012 SHALL have port rowReady  output  1  one-cycle pulse: Row just updated.
REQ-013 SHALL have port busy  output  1  high while a fetch is in progress.

Function
REQ-014 SHALL detect a request only on a 0->1 transition of LD_Row (registered previous value); a held-high LD_Row SHALL start one fetch only.
REQ-015 SHALL latch rowNum in the detect cycle (cycle 0); later rowNum changes SHALL not affect that fetch.
REQ-016 SHALL implement states IDLE, ISSUE, DRAIN, COMMIT; IDLE->ISSUE on detect with rowNum<BOARD_H; IDLE->COMMIT on detect with rowNum>=BOARD_H.
REQ-017 SHALL, in ISSUE, assert mem_rd in cycles 1..BOARD_W with mem_addr = base+k in cycle k+1, base = latched rowNum*BOARD_W computed at 8 bits (max 199, no overflow).
REQ-018 SHALL capture mem_rdata of read k into shadow buffer slot k at the end of cycle k+2; DRAIN lasts one cycle (cycle BOARD_W+1) to capture the last word.
REQ-019 SHALL, in COMMIT, copy all BOARD_W shadow slots to Row in one edge; Row SHALL never show a partially fetched row.
REQ-020 SHALL assert rowReady for exactly one cycle, the first cycle Row shows new data: cycle BOARD_W+2 (12 at default) for valid rows.
REQ-021 SHALL, for rowNum>=BOARD_H, issue no reads, commit all-zero Row, rowReady in cycle 2.
REQ-022 SHALL drive mem_rd=0 and mem_addr=0 outside ISSUE.
REQ-023 SHALL, on a new LD_Row rising edge in ISSUE/DRAIN/COMMIT, abort: discard shadow, no commit, no rowReady, restart at cycle 0 with the new rowNum; Row keeps previous value.
REQ-024 SHALL hold busy=1 from cycle 1 through the COMMIT cycle, 0 in IDLE.
REQ-025 SHALL return to IDLE after COMMIT; an edge in the rowReady cycle SHALL start a new fetch normally.

Reset
REQ-026 SHALL, on reset_n low, asynchronously set state IDLE, Row all zero, shadow zero, rowReady 0, busy 0, mem_rd 0, mem_addr 0, LD_Row history 0.
REQ-027 SHALL abandon any fetch in progress on reset without committing; LD_Row high at reset release SHALL count as a rising edge.

Structure
REQ-028 SHALL take BOARD_W, BOARD_H, CELL_W defaults and the cell_t typedef from shared package tetris_pkg, also used by color_mapper and board RAM.
REQ-029 SHALL keep the state enum local; no sub-module; board RAM (board_ram) is external.

Verification
REQ-030 SHALL cover: RAM cell n = n, LD_Row 0->1 with rowNum=3 -> mem_addr 30..39 cycles 1..10, rowReady cycle 12, Row[c]=30+c.
REQ-031 SHALL cover: LD_Row held high 40 cycles, rowNum=5 -> exactly one fetch, one rowReady pulse.
REQ-032 SHALL cover: rowNum=25 -> no mem_rd, Row all 0, rowReady cycle 2.
REQ-033 SHALL cover: fetch row 2, LD_Row re-rises cycle 6 with rowNum=7 -> no rowReady for row 2, mem_addr 70..79, Row[c]=70+c.
REQ-034 SHALL cover: reset_n low in cycle 8 of row 4 fetch after row 1 committed -> Row all 0 immediately, busy 0, no rowReady.
REQ-035 SHALL cover: rowNum=19 -> mem_addr 190..199, Row[c]=190+c, rowReady cycle 12.

Source files
------------

// File: rtl/tetris_pkg.sv
//------------------------------------------------------------------------------
// tetris_pkg
//   Shared board geometry and the cell colour word. The board RAM, the
//   colour mapper and the row fetcher all take their sizes from here, so the
//   three blocks always agree on the board layout.
//
//   cell_t : one board cell, [11:8] R, [7:4] G, [3:0] B, upper bits spare.
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tetris_pkg;

  localparam int DEF_BOARD_W = 10;  // cells per board row
  localparam int DEF_BOARD_H = 20;  // rows per board
  localparam int DEF_CELL_W  = 16;  // bits per cell colour word

  typedef logic [DEF_CELL_W-1:0] cell_t;

endpackage : tetris_pkg

`default_nettype wire

// File: rtl/board_row_fetcher.sv
//------------------------------------------------------------------------------
// board_row_fetcher
//   Fetches one board row from the external board RAM into a shadow buffer,
//   then publishes the complete row on Row in a single clock edge so the
//   colour mapper never sees a half-fetched row.
//
//   Ports
//     Clk        in   system clock, all state on the rising edge
//     reset_n    in   asynchronous active-low reset
//     LD_Row     in   row-load request level; a 0->1 edge starts a fetch
//     rowNum     in   row index, sampled in the cycle the edge is seen
//     mem_rd     out  board RAM read strobe
//     mem_addr   out  board RAM cell address, row*BOARD_W+col
//     mem_rdata  in   board RAM data, valid one cycle after mem_rd
//     Row        out  committed row image, Row[col]
//     rowReady   out  one-cycle pulse in the first cycle Row shows new data
//     busy       out  high while a fetch is in progress
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module board_row_fetcher
  import tetris_pkg::*;
#(
  parameter int BOARD_W = DEF_BOARD_W,
  parameter int BOARD_H = DEF_BOARD_H,
  parameter int CELL_W  = DEF_CELL_W
) (
  input  logic                           Clk,
  input  logic                           reset_n,
  input  logic                           LD_Row,
  input  logic [7:0]                     rowNum,
  output logic                           mem_rd,
  output logic [7:0]                     mem_addr,
  input  logic [CELL_W-1:0]              mem_rdata,
  output logic [BOARD_W-1:0][CELL_W-1:0] Row,
  output logic                           rowReady,
  output logic                           busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  localparam int              IDX_W     = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BOARD_W - 1);
  localparam logic [7:0]      BOARD_W_8 = 8'(BOARD_W);

  state_t                           state;
  state_t                           state_nx;
  logic                             ld_prev;
  logic                             detect;
  logic                             row_in_range;
  logic                             row_valid;
  logic [7:0]                       row_base;
  logic [IDX_W-1:0]                 cnt;
  logic                             cap_valid;
  logic [IDX_W-1:0]                 cap_idx;
  logic [BOARD_W-1:0][CELL_W-1:0]   shadow;
  logic [BOARD_W-1:0][CELL_W-1:0]   shadow_nx;
  logic                             commit;

  // A request is a rising edge of LD_Row. ld_prev resets to 0, so a level
  // already high when reset releases is treated as a fresh request.
  assign detect       = LD_Row & ~ld_prev;
  assign row_in_range = int'(rowNum) < BOARD_H;
  assign busy         = (state != ST_IDLE);

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  //--------------------------------------------------------------------------
  // Next state and outputs
  //   A new request wins in every state: whatever was in flight is dropped
  //   and the new row starts from scratch.
  //   For an in-range row the commit edge is the one that ends DRAIN: the
  //   last RAM word is forwarded straight into Row, so the row is visible
  //   (and rowReady high) during the COMMIT cycle. An out-of-range row has no
  //   reads to wait for and commits its zero row on the edge ending COMMIT.
  //--------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    mem_rd   = 1'b0;
    mem_addr = 8'd0;
    commit   = 1'b0;

    if (detect) begin
      state_nx = row_in_range ? ST_ISSUE : ST_COMMIT;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nx = ST_IDLE;
        end
        ST_ISSUE: begin
          if (cnt == LAST_IDX) begin
            state_nx = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state_nx = ST_COMMIT;
          commit   = 1'b1;
        end
        ST_COMMIT: begin
          state_nx = ST_IDLE;
          commit   = ~row_valid;
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end

    if (state == ST_ISSUE) begin
      mem_rd   = 1'b1;
      mem_addr = row_base + 8'(cnt);
    end
  end

  //--------------------------------------------------------------------------
  // Shadow buffer with the word arriving this cycle merged in
  //--------------------------------------------------------------------------
  always_comb begin
    shadow_nx = shadow;
    if (cap_valid) begin
      shadow_nx[cap_idx] = mem_rdata;
    end
  end

  //--------------------------------------------------------------------------
  // Datapath
  //--------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_prev   <= 1'b0;
      row_valid <= 1'b0;
      row_base  <= 8'd0;
      cnt       <= '0;
      cap_valid <= 1'b0;
      cap_idx   <= '0;
      shadow    <= '0;
      Row       <= '0;
      rowReady  <= 1'b0;
    end else begin
      ld_prev  <= LD_Row;
      rowReady <= commit;
      cap_idx  <= cnt;
      // A read issued in the cycle a new request arrives belongs to the
      // abandoned fetch, so its data is never captured.
      cap_valid <= mem_rd & ~detect;

      if (detect) begin
        // 8-bit product: the largest legal base is 19*10 = 190.
        row_base  <= rowNum * BOARD_W_8;
        row_valid <= row_in_range;
        cnt       <= '0;
        shadow    <= '0;
      end else begin
        shadow <= shadow_nx;
        if (state == ST_ISSUE) begin
          cnt <= cnt + IDX_W'(1);
        end
      end

      if (commit) begin
        Row <= shadow_nx;
      end
    end
  end

endmodule : board_row_fetcher

`default_nettype wire

// File: tb/tb_board_row_fetcher.sv
//------------------------------------------------------------------------------
// tb_board_row_fetcher
//   Self-checking bench for board_row_fetcher. A board RAM model returns
//   cell n = n one cycle after each read. Each scenario pushes the expected
//   reads and row commits (with the cycle they must appear in) to scoreboard
//   queues; a monitor records what the DUT actually does, and the scenario
//   pops and compares the two.
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_board_row_fetcher;
  import tetris_pkg::*;

  localparam int BW = 10;
  localparam int BH = 20;

  typedef struct packed {
    int         cyc;
    logic [7:0] addr;
  } rd_ev_t;

  typedef struct packed {
    int                    cyc;
    logic [BW-1:0][15:0]   row;
  } row_ev_t;

  localparam rd_ev_t  NO_RD  = '{cyc: -1, addr: 8'h00};
  localparam row_ev_t NO_ROW = '{cyc: -1, row: '0};

  logic                Clk = 1'b0;
  logic                reset_n;
  logic                LD_Row;
  logic [7:0]          rowNum;
  logic                mem_rd;
  logic [7:0]          mem_addr;
  cell_t               mem_rdata;
  logic [BW-1:0][15:0] Row;
  logic                rowReady;
  logic                busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stray_addr = 0;

  rd_ev_t  exp_rd[$];
  rd_ev_t  obs_rd[$];
  row_ev_t exp_rdy[$];
  row_ev_t obs_rdy[$];

  board_row_fetcher #(
    .BOARD_W (BW),
    .BOARD_H (BH),
    .CELL_W  (16)
  ) dut (
    .Clk       (Clk),
    .reset_n   (reset_n),
    .LD_Row    (LD_Row),
    .rowNum    (rowNum),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .Row       (Row),
    .rowReady  (rowReady),
    .busy      (busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Board RAM: cell n holds n, data one cycle after the strobe; junk otherwise.
  always @(posedge Clk) begin
    if (mem_rd) mem_rdata <= {8'h00, mem_addr};
    else        mem_rdata <= 16'hDEAD;
  end

  // Monitor: record reads and row publications with their cycle stamp.
  always @(negedge Clk) begin
    if (mem_rd) obs_rd.push_back('{cyc: cyc, addr: mem_addr});
    else if (mem_addr !== 8'd0) stray_addr <= stray_addr + 1;
    if (rowReady) obs_rdy.push_back('{cyc: cyc, row: Row});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // Advance n rising edges, then step just past the edge to drive inputs.
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Expected behaviour of one fetch whose cycle 0 is t0.
  task automatic push_fetch(input int r, input int t0);
    row_ev_t ev;
    ev.row = '0;
    if (r < BH) begin
      for (int k = 0; k < BW; k++) begin
        exp_rd.push_back('{cyc: t0 + 1 + k, addr: 8'(r * BW + k)});
        ev.row[k] = 16'(r * BW + k);
      end
      ev.cyc = t0 + BW + 2;
    end else begin
      ev.cyc = t0 + 2;
    end
    exp_rdy.push_back(ev);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; LD_Row = 1'b0; rowNum = 8'd0;
    tick(3);
    total++; if (Row !== '0)        begin bad++; $display("FAIL reset_row: got %h want 0", Row); end
    total++; if (rowReady !== 1'b0) begin bad++; $display("FAIL reset_rowReady: got %b want 0", rowReady); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (mem_rd !== 1'b0)   begin bad++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
    total++; if (mem_addr !== 8'd0) begin bad++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
    reset_n = 1'b1;
    tick(2);
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic_row3;
    int t0; int s0; rd_ev_t e, o; row_ev_t er, orw; logic [BW-1:0][15:0] prev;
    s0 = stray_addr;
    tick(1);
    LD_Row = 1'b1; rowNum = 8'd3; t0 = cyc; prev = Row;
    push_fetch(3, t0);
    for (int n = 0; n <= 14; n++) begin
      @(negedge Clk);
      total++;
      if (busy !== (n >= 1 && n <= 12)) begin bad++; $display("FAIL basic_busy c%0d: got %b want %b", n, busy, (n >= 1 && n <= 12)); end
      if (n < 12) begin
        total++;
        if (Row !== prev) begin bad++; $display("FAIL basic_row_partial c%0d: got %h want %h", n, Row, prev); end
      end
      if (n == 1) begin LD_Row = 1'b0; rowNum = 8'hAA; end
    end
    tick(2);
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front(); o = NO_RD; if (obs_rd.size() > 0) o = obs_rd.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL basic_rd: got addr %0d cyc %0d want addr %0d cyc %0d", o.addr, o.cyc - t0, e.addr, e.cyc - t0); end
    end
    while (exp_rdy.size() > 0) begin
      er = exp_rdy.pop_front(); orw = NO_ROW; if (obs_rdy.size() > 0) orw = obs_rdy.pop_front();
      total++; if (orw !== er) begin bad++; $display("FAIL basic_rdy: got cyc %0d row %h want cyc %0d row %h", orw.cyc - t0, orw.row, er.cyc - t0, er.row); end
    end
    total++; if (obs_rd.size() + obs_rdy.size() != 0) begin bad++; $display("FAIL basic_extra: got %0d extra events want 0", obs_rd.size() + obs_rdy.size()); end
    total++; if (stray_addr != s0) begin bad++; $display("FAIL basic_addr_idle: got %0d nonzero idle addrs want 0", stray_addr - s0); end
    obs_rd.delete(); obs_rdy.delete();
  endtask

  task automatic test_held_high;
    int t0; rd_ev_t e, o; row_ev_t er, orw;
    tick(1);
    LD_Row = 1'b1; rowNum = 8'd5; t0 = cyc;
    push_fetch(5, t0);
    tick(1); rowNum = 8'd9;
    tick(39);
    LD_Row = 1'b0;
    tick(3);
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front(); o = NO_RD; if (obs_rd.size() > 0) o = obs_rd.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL held_rd: got addr %0d cyc %0d want addr %0d cyc %0d", o.addr, o.cyc - t0, e.addr, e.cyc - t0); end
    end
    while (exp_rdy.size() > 0) begin
      er = exp_rdy.pop_front(); orw = NO_ROW; if (obs_rdy.size() > 0) orw = obs_rdy.pop_front();
      total++; if (orw !== er) begin bad++; $display("FAIL held_rdy: got cyc %0d row %h want cyc %0d row %h", orw.cyc - t0, orw.row, er.cyc - t0, er.row); end
    end
    total++; if (obs_rd.size() + obs_rdy.size() != 0) begin bad++; $display("FAIL held_extra: got %0d extra events want 0", obs_rd.size() + obs_rdy.size()); end
    obs_rd.delete(); obs_rdy.delete();
  endtask

  task automatic test_out_of_range;
    int t0; row_ev_t er, orw;
    tick(1);
    LD_Row = 1'b1; rowNum = 8'd25; t0 = cyc;
    push_fetch(25, t0);
    tick(1); LD_Row = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL oor_busy_c1: got %b want 1", busy); end
    tick(6);
    while (exp_rdy.size() > 0) begin
      er = exp_rdy.pop_front(); orw = NO_ROW; if (obs_rdy.size() > 0) orw = obs_rdy.pop_front();
      total++; if (orw !== er) begin bad++; $display("FAIL oor_rdy: got cyc %0d row %h want cyc %0d row %h", orw.cyc - t0, orw.row, er.cyc - t0, er.row); end
    end
    total++; if (obs_rd.size() + obs_rdy.size() != 0) begin bad++; $display("FAIL oor_extra: got %0d extra events want 0", obs_rd.size() + obs_rdy.size()); end
    obs_rd.delete(); obs_rdy.delete();
  endtask

  task automatic test_abort;
    int t0, t1; rd_ev_t e, o; row_ev_t er, orw;
    tick(1);
    LD_Row = 1'b1; rowNum = 8'd2; t0 = cyc;
    for (int k = 0; k < 6; k++) exp_rd.push_back('{cyc: t0 + 1 + k, addr: 8'(20 + k)});
    tick(1); LD_Row = 1'b0;
    tick(5);
    LD_Row = 1'b1; rowNum = 8'd7; t1 = cyc;
    push_fetch(7, t1);
    tick(1); LD_Row = 1'b0;
    tick(15);
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front(); o = NO_RD; if (obs_rd.size() > 0) o = obs_rd.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL abort_rd: got addr %0d cyc %0d want addr %0d cyc %0d", o.addr, o.cyc - t0, e.addr, e.cyc - t0); end
    end
    while (exp_rdy.size() > 0) begin
      er = exp_rdy.pop_front(); orw = NO_ROW; if (obs_rdy.size() > 0) orw = obs_rdy.pop_front();
      total++; if (orw !== er) begin bad++; $display("FAIL abort_rdy: got cyc %0d row %h want cyc %0d row %h", orw.cyc - t1, orw.row, er.cyc - t1, er.row); end
    end
    total++; if (obs_rd.size() + obs_rdy.size() != 0) begin bad++; $display("FAIL abort_extra: got %0d extra events want 0", obs_rd.size() + obs_rdy.size()); end
    obs_rd.delete(); obs_rdy.delete();
  endtask

  task automatic test_reset_mid_fetch;
    int t0, t1; rd_ev_t e, o; row_ev_t er, orw;
    tick(1);
    LD_Row = 1'b1; rowNum = 8'd1; t0 = cyc;
    push_fetch(1, t0);
    tick(1); LD_Row = 1'b0;
    tick(15);
    LD_Row = 1'b1; rowNum = 8'd4; t1 = cyc;
    for (int k = 0; k < 7; k++) exp_rd.push_back('{cyc: t1 + 1 + k, addr: 8'(40 + k)});
    tick(1); LD_Row = 1'b0;
    tick(7);
    reset_n = 1'b0;
    #1;
    total++; if (Row !== '0)      begin bad++; $display("FAIL rstmid_row: got %h want 0", Row); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL rstmid_mem_rd: got %b want 0", mem_rd); end
    tick(2);
    reset_n = 1'b1;
    tick(20);
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front(); o = NO_RD; if (obs_rd.size() > 0) o = obs_rd.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL rstmid_rd: got addr %0d cyc %0d want addr %0d cyc %0d", o.addr, o.cyc, e.addr, e.cyc); end
    end
    while (exp_rdy.size() > 0) begin
      er = exp_rdy.pop_front(); orw = NO_ROW; if (obs_rdy.size() > 0) orw = obs_rdy.pop_front();
      total++; if (orw !== er) begin bad++; $display("FAIL rstmid_rdy: got cyc %0d row %h want cyc %0d row %h", orw.cyc - t0, orw.row, er.cyc - t0, er.row); end
    end
    total++; if (obs_rd.size() + obs_rdy.size() != 0) begin bad++; $display("FAIL rstmid_extra: got %0d extra events want 0", obs_rd.size() + obs_rdy.size()); end
    total++; if (Row !== '0) begin bad++; $display("FAIL rstmid_row_after: got %h want 0", Row); end
    obs_rd.delete(); obs_rdy.delete();
  endtask

  task automatic test_last_row;
    int t0; rd_ev_t e, o; row_ev_t er, orw;
    tick(1);
    LD_Row = 1'b1; rowNum = 8'd19; t0 = cyc;
    push_fetch(19, t0);
    tick(1); LD_Row = 1'b0;
    tick(16);
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front(); o = NO_RD; if (obs_rd.size() > 0) o = obs_rd.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL last_rd: got addr %0d cyc %0d want addr %0d cyc %0d", o.addr, o.cyc - t0, e.addr, e.cyc - t0); end
    end
    while (exp_rdy.size() > 0) begin
      er = exp_rdy.pop_front(); orw = NO_ROW; if (obs_rdy.size() > 0) orw = obs_rdy.pop_front();
      total++; if (orw !== er) begin bad++; $display("FAIL last_rdy: got cyc %0d row %h want cyc %0d row %h", orw.cyc - t0, orw.row, er.cyc - t0, er.row); end
    end
    total++; if (obs_rd.size() + obs_rdy.size() != 0) begin bad++; $display("FAIL last_extra: got %0d extra events want 0", obs_rd.size() + obs_rdy.size()); end
    obs_rd.delete(); obs_rdy.delete();
  endtask

  task automatic test_back_to_back;
    int t0, t1; rd_ev_t e, o; row_ev_t er, orw;
    tick(1);
    LD_Row = 1'b1; rowNum = 8'd0; t0 = cyc;
    push_fetch(0, t0);
    tick(1); LD_Row = 1'b0;
    tick(11);
    total++; if (rowReady !== 1'b1) begin bad++; $display("FAIL b2b_rowReady_c12: got %b want 1", rowReady); end
    LD_Row = 1'b1; rowNum = 8'd11; t1 = cyc;
    push_fetch(11, t1);
    tick(1); LD_Row = 1'b0;
    tick(16);
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front(); o = NO_RD; if (obs_rd.size() > 0) o = obs_rd.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL b2b_rd: got addr %0d cyc %0d want addr %0d cyc %0d", o.addr, o.cyc - t0, e.addr, e.cyc - t0); end
    end
    while (exp_rdy.size() > 0) begin
      er = exp_rdy.pop_front(); orw = NO_ROW; if (obs_rdy.size() > 0) orw = obs_rdy.pop_front();
      total++; if (orw !== er) begin bad++; $display("FAIL b2b_rdy: got cyc %0d row %h want cyc %0d row %h", orw.cyc - t0, orw.row, er.cyc - t0, er.row); end
    end
    total++; if (obs_rd.size() + obs_rdy.size() != 0) begin bad++; $display("FAIL b2b_extra: got %0d extra events want 0", obs_rd.size() + obs_rdy.size()); end
    obs_rd.delete(); obs_rdy.delete();
  endtask

  initial begin
    test_reset;
    test_basic_row3;
    test_held_high;
    test_out_of_range;
    test_abort;
    test_reset_mid_fetch;
    test_last_row;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_board_row_fetcher

`default_nettype wire
